// File: rtl/conv3x3_window_gen.sv
// Streaming 3x3 sliding-window generator: two line buffers feed a 3x3 register
// window whose nine taps drive the conv MAC stage directly, with position tags.
module conv3x3_window_gen #(
    parameter int DATA_W = 16,
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int CW     = $clog2(IMG_W),
    parameter int RW     = $clog2(IMG_H)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] pix_in,
    input  logic              pix_valid,
    output logic              pix_ready,
    output logic [DATA_W-1:0] win0,
    output logic [DATA_W-1:0] win1,
    output logic [DATA_W-1:0] win2,
    output logic [DATA_W-1:0] win3,
    output logic [DATA_W-1:0] win4,
    output logic [DATA_W-1:0] win5,
    output logic [DATA_W-1:0] win6,
    output logic [DATA_W-1:0] win7,
    output logic [DATA_W-1:0] win8,
    output logic              win_valid,
    input  logic              win_ready,
    output logic [RW-1:0]     win_row,
    output logic [CW-1:0]     win_col,
    output logic              frame_done
);

    // Handshake: a beat transfers on a rising edge where valid && ready. A
    // presented window (win_valid) holds all taps and tags until win_ready; a
    // new pixel is taken only when the current window leaves that same cycle.
    logic [DATA_W-1:0] r_lb0 [IMG_W];
    logic [DATA_W-1:0] r_lb1 [IMG_W];
    logic [DATA_W-1:0] r_win [9];
    logic [CW-1:0]     r_col;
    logic [RW-1:0]     r_row;
    logic              r_win_valid;
    logic [RW-1:0]     r_win_row;
    logic [CW-1:0]     r_win_col;
    logic              r_frame_done;

    logic              w_accept;
    logic              w_col_last;
    logic              w_row_last;
    logic              w_win_done;
    logic [DATA_W-1:0] w_lb0_rd;
    logic [DATA_W-1:0] w_lb1_rd;

    assign pix_ready  = !r_win_valid || win_ready;
    assign w_accept   = pix_valid && pix_ready;
    assign w_col_last = (r_col == CW'(IMG_W - 1));
    assign w_row_last = (r_row == RW'(IMG_H - 1));
    assign w_win_done = (r_row >= RW'(2)) && (r_col >= CW'(2));
    assign w_lb0_rd   = r_lb0[r_col];
    assign w_lb1_rd   = r_lb1[r_col];

    // Raster position of the next pixel to be accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_accept) begin
            if (w_col_last) begin
                r_col <= '0;
                r_row <= w_row_last ? '0 : r_row + RW'(1);
            end else begin
                r_col <= r_col + CW'(1);
            end
        end
    end

    // Line buffers are not reset; the row/column mask hides stale contents.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_lb1[r_col] <= w_lb0_rd;
            r_lb0[r_col] <= pix_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 9; k++) begin
                r_win[k] <= '0;
            end
        end else if (w_accept) begin
            for (int i = 0; i < 3; i++) begin
                r_win[3*i]   <= r_win[3*i+1];
                r_win[3*i+1] <= r_win[3*i+2];
            end
            r_win[2] <= w_lb1_rd;
            r_win[5] <= w_lb0_rd;
            r_win[8] <= pix_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_win_valid  <= 1'b0;
            r_win_row    <= '0;
            r_win_col    <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_accept && w_col_last && w_row_last;
            if (w_accept) begin
                r_win_valid <= w_win_done;
                if (w_win_done) begin
                    r_win_row <= r_row - RW'(2);
                    r_win_col <= r_col - CW'(2);
                end
            end else if (win_ready) begin
                r_win_valid <= 1'b0;
            end
        end
    end

    assign win0       = r_win[0];
    assign win1       = r_win[1];
    assign win2       = r_win[2];
    assign win3       = r_win[3];
    assign win4       = r_win[4];
    assign win5       = r_win[5];
    assign win6       = r_win[6];
    assign win7       = r_win[7];
    assign win8       = r_win[8];
    assign win_valid  = r_win_valid;
    assign win_row    = r_win_row;
    assign win_col    = r_win_col;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_conv3x3_window_gen.sv
// Bench for conv3x3_window_gen: a 4x4 instance for the directed cases and a
// default 28x28 instance for the full-frame case, sharing one stimulus bus.
module tb_conv3x3_window_gen;

    localparam int EW = 9 * 16 + 16;

    logic        clk;
    logic        rst;
    logic [15:0] pix_in;
    logic        pix_valid;
    logic        win_ready;
    logic        sel28;

    logic        prdy4, wv4, fd4;
    logic [15:0] w4 [9];
    logic [1:0]  row4, col4;
    logic        prdy28, wv28, fd28;
    logic [15:0] w28 [9];
    logic [4:0]  row28, col28;

    logic            m_valid, m_fd, m_prdy;
    logic [8:0][15:0] m_taps;
    logic [7:0]      m_row, m_col;

    logic [EW-1:0] exp_q[$];
    int            lat_q[$];
    int            fd_q[$];
    int            n_cmp = 0;
    int            n_err = 0;
    int            cyc = 0;
    int            rdy_mode = 0;

    conv3x3_window_gen #(.DATA_W(16), .IMG_W(4), .IMG_H(4)) u_dut4 (
        .clk(clk), .rst(rst), .pix_in(pix_in), .pix_valid(pix_valid), .pix_ready(prdy4),
        .win0(w4[0]), .win1(w4[1]), .win2(w4[2]), .win3(w4[3]), .win4(w4[4]),
        .win5(w4[5]), .win6(w4[6]), .win7(w4[7]), .win8(w4[8]),
        .win_valid(wv4), .win_ready(win_ready), .win_row(row4), .win_col(col4),
        .frame_done(fd4)
    );

    conv3x3_window_gen u_dut28 (
        .clk(clk), .rst(rst), .pix_in(pix_in), .pix_valid(pix_valid), .pix_ready(prdy28),
        .win0(w28[0]), .win1(w28[1]), .win2(w28[2]), .win3(w28[3]), .win4(w28[4]),
        .win5(w28[5]), .win6(w28[6]), .win7(w28[7]), .win8(w28[8]),
        .win_valid(wv28), .win_ready(win_ready), .win_row(row28), .win_col(col28),
        .frame_done(fd28)
    );

    always_comb begin
        if (sel28) begin
            m_valid = wv28;
            m_fd    = fd28;
            m_prdy  = prdy28;
            m_row   = 8'(row28);
            m_col   = 8'(col28);
            for (int k = 0; k < 9; k++) m_taps[k] = w28[k];
        end else begin
            m_valid = wv4;
            m_fd    = fd4;
            m_prdy  = prdy4;
            m_row   = 8'(row4);
            m_col   = 8'(col4);
            for (int k = 0; k < 9; k++) m_taps[k] = w4[k];
        end
    end

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        n_cmp++;
        n_err++;
        $display("FAIL watchdog: actual time %0t required finish earlier", $time);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    // Reference window: pixel (r,c) of a frame holds base + r*w + c.
    function automatic logic [EW-1:0] mk_win(input int base, input int w, input int rr, input int cc);
        logic [8:0][15:0] t;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                t[i*3+j] = 16'(base + (rr + i) * w + cc + j);
        return {t, 8'(rr), 8'(cc)};
    endfunction

    // Downstream ready: 0 = always ready, 1 = random, 2 = driven by the test
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 0) win_ready = 1'b1;
            else if (rdy_mode == 1) win_ready = 1'($urandom_range(1));
        end
    end

    // Driver: present one pixel, return at posedge+1 after it is accepted
    task automatic send_pix(input logic [15:0] v, input int gap_pct);
        int waited;
        while (int'($urandom_range(99)) < gap_pct) begin
            pix_valid = 1'b0;
            @(posedge clk);
            #1;
        end
        pix_valid = 1'b1;
        pix_in    = v;
        waited    = 0;
        forever begin
            @(negedge clk);
            if (m_prdy) break;
            waited++;
            if (waited > 200) begin
                n_cmp++;
                n_err++;
                $display("FAIL pix_accept_timeout: actual pix_ready 0 for %0d cycles required 1", waited);
                $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
                $finish;
            end
        end
        @(posedge clk);
        #1;
        pix_valid = 1'b0;
    endtask

    task automatic send_frame(input int base, input int w, input int h, input int gap_pct, input int npix);
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                if (r * w + c >= npix) return;
                if (r >= 2 && c >= 2) exp_q.push_back(mk_win(base, w, r - 2, c - 2));
                send_pix(16'(base + r * w + c), gap_pct);
                if (r >= 2 && c >= 2) lat_q.push_back(cyc);
                if (r == h - 1 && c == w - 1) fd_q.push_back(cyc);
            end
        end
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || m_valid) && k < 200) begin
            @(posedge clk);
            #1;
            k++;
        end
        @(posedge clk);
        #1;
        check({name, "_leftover"}, EW'(exp_q.size() + lat_q.size() + fd_q.size()), '0);
    endtask

    // Scoreboard monitor
    initial begin
        logic prev_valid;
        logic prev_fire;
        logic [EW-1:0] act;
        prev_valid = 1'b0;
        prev_fire  = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_valid = 1'b0;
                prev_fire  = 1'b0;
            end else begin
                act = {m_taps, m_row, m_col};
                if (m_valid) begin
                    if (!prev_valid || prev_fire) begin
                        if (lat_q.size() == 0) begin
                            n_cmp++;
                            n_err++;
                            $display("FAIL win_appear: actual new window at cycle %0d required none", cyc);
                        end else begin
                            check("win_latency", EW'(cyc), EW'(lat_q.pop_front()));
                        end
                    end
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL win_unexpected: actual %h required no window", act);
                    end else begin
                        check("win_data", act, exp_q[0]);
                        if (win_ready) void'(exp_q.pop_front());
                    end
                end
                if (m_fd) begin
                    if (fd_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL frame_done_unexpected: actual pulse at cycle %0d required none", cyc);
                    end else begin
                        check("frame_done_cycle", EW'(cyc), EW'(fd_q.pop_front()));
                    end
                end
                prev_valid = m_valid;
                prev_fire  = m_valid && win_ready;
            end
        end
    end

    initial begin
        rst       = 1'b1;
        pix_valid = 1'b0;
        pix_in    = '0;
        win_ready = 1'b1;
        sel28     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_taps_tags", {m_taps, m_row, m_col}, '0);
        check("reset_ctrl", EW'({m_valid, m_fd, m_prdy}), EW'(3'b001));
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Full-rate 4x4 frame
        send_frame(0, 4, 4, 0, 16);
        drain("t1");

        // First window stalled for five cycles
        rdy_mode  = 2;
        win_ready = 1'b0;
        fork
            send_frame(0, 4, 4, 0, 16);
            begin
                int k;
                k = 0;
                while (!m_valid && k < 100) begin
                    @(negedge clk);
                    k++;
                end
                check("stall_win_valid", EW'(m_valid), EW'(1));
                for (int i = 0; i < 5; i++) begin
                    check("stall_pix_ready", EW'(m_prdy), EW'(0));
                    if (i < 4) @(negedge clk);
                end
                @(posedge clk);
                #1;
                win_ready = 1'b1;
                rdy_mode  = 0;
            end
        join
        drain("t2");

        // Random input gaps and random downstream ready
        rdy_mode = 1;
        send_frame(0, 4, 4, 50, 16);
        drain("t3");

        // Two frames back-to-back
        send_frame(0, 4, 4, 0, 16);
        send_frame(100, 4, 4, 0, 16);
        drain("t4");
        rdy_mode = 0;

        // Asynchronous reset mid-frame after pixel 9
        send_frame(0, 4, 4, 0, 10);
        #2;
        rst = 1'b1;
        #1;
        check("midreset_taps_tags", {m_taps, m_row, m_col}, '0);
        check("midreset_ctrl", EW'({m_valid, m_fd, m_prdy}), EW'(3'b001));
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        send_frame(0, 4, 4, 0, 16);
        drain("t5");

        // Default 28x28 full frame
        rst   = 1'b1;
        sel28 = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        send_frame(0, 28, 28, 0, 784);
        drain("t6");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/conv3x3_window_gen.md
Name: conv3x3_window_gen

Overview:
Streaming 3x3 sliding-window generator that feeds the 3x3 convolution datapath.
- Accepts a raster-order pixel stream, one pixel per accepted beat.
- Uses two internal line buffers plus a 3x3 register window.
- Emits nine window taps that map directly onto the conv unit's in0..in8 inputs, with a valid/ready handshake and position tags.
- Sits between the image source (frame memory or previous layer) and the conv MAC stage.

Parameters:
DATA_W, 16, pixel/tap width in bits
IMG_W, 28, image width in pixels (>=3)
IMG_H, 28, image height in pixels (>=3)
CW, $clog2(IMG_W), column counter/tag width
RW, $clog2(IMG_H), row counter/tag width

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous reset, active-high
pix_in  in  DATA_W  input pixel, raster order, row-major
pix_valid  in  1  pix_in valid
pix_ready  out  1  block can accept pix_in this cycle
win0..win8  out  DATA_W each  window taps, row-major; win0 = top-left (r-2,c-2), win4 = centre, win8 = bottom-right (current pixel)
win_valid  out  1  window taps valid
win_ready  in  1  downstream accepts window
win_row  out  RW  row of win0 (top-left) in image
win_col  out  CW  column of win0 (top-left) in image
frame_done  out  1  one-cycle pulse after the last pixel of a frame is accepted

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high (rst).
- Reset values: win0..win8 = 0, win_valid = 0, win_row = 0, win_col = 0, frame_done = 0, row/col counters = 0. pix_ready goes to 1 combinationally once win_valid = 0. Line-buffer RAM is not reset; stale contents are masked by the validity rule below.
- pix_ready = !win_valid || win_ready (combinational). Accept = pix_valid && pix_ready. Gaps in pix_valid are legal and change no state.
- On accept at position (r,c):
  - Each of the 3 window rows shifts left by one column.
  - The new right column is {lb1[c], lb0[c], pix_in}, top to bottom.
  - Then lb1[c] <= lb0[c] and lb0[c] <= pix_in.
- Window complete when the accept happens at r>=2 && c>=2. The registered outputs update on that edge:
  - win_valid <= 1, win_row <= r-2, win_col <= c-2.
  - Latency is 1 cycle from accepting the bottom-right pixel to win_valid.
- Accept that does not complete a window (r<2 or c<2): win_valid <= 0. The previous window was consumed that same cycle, because pix_ready implies it.
- No accept and win_valid && win_ready: win_valid <= 0.
- While win_valid && !win_ready, all win*/tag outputs hold stable and no pixel is accepted.
- Counters:
  - col increments per accept and wraps IMG_W-1 -> 0; row increments on col wrap.
  - At (IMG_H-1, IMG_W-1), row and col wrap to 0 and frame_done pulses for exactly one cycle, on the edge after that accept.
  - The next frame starts immediately; back-to-back frames need no idle cycles.
- Per frame: exactly (IMG_W-2)*(IMG_H-2) windows are emitted. No window spans a row boundary or a frame boundary, which the r/c masking guarantees.
- Mid-frame reset: everything returns to reset values immediately (async). The next accepted pixel is treated as (0,0) of a new frame, and no partial window is emitted.
- Arithmetic: no pixel arithmetic in this block; taps are passed through bit-exact. The conv stage zero-extends them.

Test Plan:
1. IMG_W=IMG_H=4, stream pixel value = 4r+c with pix_valid=1 and win_ready=1.
   -> First win_valid arrives 1 cycle after pixel 10 is accepted, with win0..win8 = 0,1,2,4,5,6,8,9,10 and tag (0,0).
   -> Exactly 4 windows: tags (0,0),(0,1),(1,0),(1,1); the last is 5,6,7,9,10,11,13,14,15.
   -> frame_done pulses once, after pixel 15.
2. Same stream, with win_ready held low for 5 cycles on the first window.
   -> pix_ready = 0 throughout; taps and tags stay stable.
   -> After release, the remaining windows match test 1 with none lost or duplicated.
3. Random pix_valid gaps (~50%) with random win_ready.
   -> Window sequence and contents are identical to test 1; frame_done still fires once.
4. Two frames back-to-back, frame 2 values = 100+4r+c.
   -> 8 windows total; the first frame-2 window is 100,101,102,104,105,106,108,109,110 with tag (0,0).
   -> No window mixes frame-1 and frame-2 pixels.
5. Assert rst after pixel 9 of frame 1 (async, mid-cycle).
   -> All outputs go to 0 immediately.
   -> The restarted stream 0..15 produces the test-1 results exactly.
6. Default IMG_W=IMG_H=28 full frame.
   -> 676 windows; spot-check the window at tag (13,13) against the reference model.
   -> frame_done fires one cycle after pixel 783 is accepted.
